i2c_nbyte_writer: RTL
=====================

# i2c_nbyte_writer

Parametrised open-drain I2C write engine. It serialises an N-byte payload (address byte included) onto one or more selectable SCL/SDA bus pairs, with START/STOP framing and per-byte ACK sampling. A BUSY/DONE handshake lets the host controller sequence multi-register configuration writes to front-end chips. It supersedes fixed-length brute-force shift-register senders: length, bus count and bit rate are parameters, and slave ACKs are checked.

## Interface
- NBYTES, 4: bytes per transaction, 1..16; byte 0 is the 7-bit address plus R/W bit.
- NLINES, 2: number of independent SCL/SDA bus pairs, 1..8.
- QDIV, 32768: CLK cycles per quarter-bit tick, ≥2; bit period = 4·QDIV cycles.
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled high in IDLE starts a transaction.
- LINESEL  in  NLINES  bus-pair select, one bit per pair; any number of pairs can be set, and they are driven simultaneously.
- DATA  in  8·NBYTES  payload; DATA[8·NBYTES-1 -: 8] is sent first, MSB first.
- SDA_IN  in  NLINES  bus SDA readback for ACK sampling.
- SCL_OE  out  NLINES  1 = pull SCL low, 0 = release.
- SDA_OE  out  NLINES  1 = pull SDA low, 0 = release.
- BUSY  out  1  high while a transaction is in progress.
- DONE  out  1  one-cycle pulse at transaction end.
- NACK  out  1  at least one byte was not acknowledged; holds until next accepted START.
- NACK_BYTE  out  clog2(NBYTES)+1  index of the first NACKed byte; holds until next accepted START.

## Operation
- **Tick generator.** Divider counts 0..QDIV-1 and is cleared on START acceptance. The tick fires when the count reaches QDIV-1 and advances one quarter-bit phase (q0..q3).
- **START acceptance.** Requires START=1, state IDLE and LINESEL≠0. DATA and LINESEL are latched; NACK and NACK_BYTE are cleared. START with LINESEL=0, or while BUSY, is ignored.
- **FSM states:** IDLE, STA, BIT, ACK, STO.
- **STA:** q0 SCL and SDA released; q1 SDA low; q2 SCL low; q3 hold.
- **BIT:**
  - q0: SCL low; SDA set to the current bit (0 → pull low, 1 → release).
  - q1, q2: SCL released.
  - q3: SCL low.
  - After 8 bits → ACK.
- **ACK:** SDA released; SCL follows the BIT pattern.
  - At the q2 tick, ack = OR of SDA_IN over latched LINESEL; any selected pair high = NACK.
  - On the first NACK: NACK←1, NACK_BYTE←byte index.
  - Then next byte → BIT, or → STO after byte NBYTES-1.
- **STO:** q0 SCL low, SDA low; q1 SCL released; q2 SDA released; q3 both released → IDLE.
- **Line gating.** Only pairs selected in the latched LINESEL are driven; unselected pairs have OE=0 always. In IDLE all OE=0.
- **Arithmetic.** Bit counter 0..7, byte counter 0..NBYTES-1; neither counter wraps, and terminal values steer the FSM.

## Timing
- **Reset values:** SCL_OE=0, SDA_OE=0, BUSY=0, DONE=0, NACK=0, NACK_BYTE=0; state IDLE; divider 0.
- **Reset mid-transaction:** all lines are released immediately (asynchronously). No STOP is generated; the slave recovers on the next START.
- **BUSY:** rises on the first CLK edge after the accepting edge.
- **Transaction length:** (8 + 36·NBYTES) quarter ticks = (8 + 36·NBYTES)·QDIV cycles.
- **DONE:** pulses for one cycle on the edge where BUSY falls. START is accepted again on the cycle after DONE.
- **START held high:** back-to-back transactions result, separated by one IDLE cycle.
- **ACK sampling:** exactly one CLK cycle per ACK slot, at the q2 tick. Glitches outside that cycle are ignored.
- **OE timing:** OE outputs are registered and change only on tick edges.

## Configuration
- **I2C_NBYTE_ABORT_ON_NACK_EN**
  - Defined: a NACK in ACK jumps directly to STO; the remaining bytes are not sent, and DONE fires early.
  - Undefined: all NBYTES are always sent and NACK/NACK_BYTE report the first failure; transaction length is fixed.

## Test plan
- **Basic write with ACK.** NBYTES=4, QDIV=4, LINESEL=2'b10, DATA=32'hA0_12_34_56, slave ACKs all bytes.
  - Pair 1 carries START, A0/12/34/56 MSB-first, four ACK slots, STOP.
  - Pair 0 OE stays 0. DONE pulses after 152·4=608 cycles; NACK=0.
- **Single NACK.** Same stimulus, SDA_IN held high during the byte-2 ACK.
  - Without macro: full 608 cycles, NACK=1, NACK_BYTE=2.
  - With macro: STOP immediately follows byte-2 ACK; DONE at (8+36·3)·4=464 cycles.
- **Both pairs selected.** LINESEL=2'b11; SDA_IN[0] ACKs, SDA_IN[1] NACKs byte 0 → NACK=1, NACK_BYTE=0; both pairs are driven identically.
- **Ignored requests.** START with LINESEL=0 → BUSY stays 0. A second START pulse mid-transaction → ignored, and latched DATA is unchanged.
- **Reset mid-transaction.** Assert RST during byte 1 → all OE=0 in the same cycle, BUSY=0, no DONE. A subsequent START runs a full clean transaction.
- **Back-to-back transactions.** START held high → two transactions with exactly one IDLE cycle between the DONE pulse and the next BUSY rise.

Source files
------------

// File: rtl/i2c_nbyte_writer_if.sv
// i2c_nbyte_writer_if: host/bus-side signal bundle for i2c_nbyte_writer.
//   start      request pulse/level from the host
//   linesel    bus-pair select, one bit per SCL/SDA pair
//   data       payload, first byte in the top 8 bits, MSB first
//   sda_in     SDA readback per pair (ACK sampling)
//   scl_oe     1 = pull SCL low, per pair
//   sda_oe     1 = pull SDA low, per pair
//   busy       transaction in progress
//   done       one-cycle pulse at transaction end
//   nack       some byte was not acknowledged (sticky until next START)
//   nack_byte  index of the first non-acknowledged byte
// Modports: master = host/testbench side, slave = the writer.
interface i2c_nbyte_writer_if #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned NLINES = 2
);
    localparam int unsigned DATA_W = 8 * NBYTES;
    localparam int unsigned IDX_W  = $clog2(NBYTES) + 1;

    logic              start;
    logic [NLINES-1:0] linesel;
    logic [DATA_W-1:0] data;
    logic [NLINES-1:0] sda_in;
    logic [NLINES-1:0] scl_oe;
    logic [NLINES-1:0] sda_oe;
    logic              busy;
    logic              done;
    logic              nack;
    logic [IDX_W-1:0]  nack_byte;

    modport master (
        output start, linesel, data, sda_in,
        input  scl_oe, sda_oe, busy, done, nack, nack_byte
    );

    modport slave (
        input  start, linesel, data, sda_in,
        output scl_oe, sda_oe, busy, done, nack, nack_byte
    );
endinterface

// File: rtl/i2c_nbyte_writer.sv
// i2c_nbyte_writer: open-drain I2C write engine. Sends NBYTES bytes (byte 0 =
// address + R/W) framed by START/STOP on every selected SCL/SDA pair at once,
// sampling the slave ACK after each byte.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   asynchronous active-high reset; releases all lines immediately
//   bus   i2c_nbyte_writer_if.slave (start/linesel/data/sda_in in,
//         scl_oe/sda_oe/busy/done/nack/nack_byte out, all outputs registered)
// Build option: define I2C_NBYTE_ABORT_ON_NACK_EN to go straight to STOP
// after the first NACKed byte; by default every byte is always sent.
module i2c_nbyte_writer #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned NLINES = 2,
    parameter int unsigned QDIV   = 32768
) (
    input logic               clk,
    input logic               rst,
    i2c_nbyte_writer_if.slave bus
);
    localparam int unsigned DATA_W = 8 * NBYTES;
    localparam int unsigned IDX_W  = $clog2(NBYTES) + 1;
    localparam int unsigned DIV_W  = $clog2(QDIV);

    typedef enum logic [2:0] {IDLE, STA, BIT, ACK, STO} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div;
    logic [1:0]        ph, ph_n;
    logic [2:0]        bitc, bitc_n;
    logic [IDX_W-1:0]  bytec, bytec_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic [NLINES-1:0] lines, lines_n;
    logic [NLINES-1:0] scl_oe, sda_oe;
    logic              busy, busy_n;
    logic              done, done_n;
    logic              nack, nack_n;
    logic [IDX_W-1:0]  nack_byte, nack_byte_n;

    logic tick, accept, ack_fail, abort_now, scl_low, sda_low;

    assign tick     = (div == DIV_W'(QDIV - 1));
    assign ack_fail = |(bus.sda_in & lines);

`ifdef I2C_NBYTE_ABORT_ON_NACK_EN
    assign abort_now = nack;
`else
    assign abort_now = 1'b0;
`endif

    // Next state, counters and line pattern for the phase being entered
    always_comb begin
        state_n     = state;
        ph_n        = ph;
        bitc_n      = bitc;
        bytec_n     = bytec;
        sreg_n      = sreg;
        lines_n     = lines;
        nack_n      = nack;
        nack_byte_n = nack_byte;
        done_n      = 1'b0;
        scl_low     = 1'b0;
        sda_low     = 1'b0;
        accept      = (state == IDLE) && bus.start && (bus.linesel != '0);

        if (accept) begin
            state_n     = STA;
            ph_n        = 2'd0;
            bitc_n      = 3'd0;
            bytec_n     = '0;
            sreg_n      = bus.data;
            lines_n     = bus.linesel;
            nack_n      = 1'b0;
            nack_byte_n = '0;
        end else if (tick && (state != IDLE)) begin
            ph_n = ph + 2'd1;
            // Single-cycle ACK sample; only the first failure is recorded
            if ((state == ACK) && (ph == 2'd2) && ack_fail && !nack) begin
                nack_n      = 1'b1;
                nack_byte_n = bytec;
            end
            if (ph == 2'd3) begin
                case (state)
                    STA: state_n = BIT;
                    BIT: begin
                        sreg_n = {sreg[DATA_W-2:0], 1'b0};
                        if (bitc == 3'd7) begin
                            state_n = ACK;
                        end else begin
                            bitc_n = bitc + 3'd1;
                        end
                    end
                    ACK: begin
                        if ((bytec == IDX_W'(NBYTES - 1)) || abort_now) begin
                            state_n = STO;
                        end else begin
                            state_n = BIT;
                            bitc_n  = 3'd0;
                            bytec_n = bytec + IDX_W'(1);
                        end
                    end
                    STO: begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        case (state_n)
            STA: begin
                sda_low = (ph_n != 2'd0);
                scl_low = ph_n[1];
            end
            BIT: begin
                scl_low = (ph_n == 2'd0) || (ph_n == 2'd3);
                sda_low = ~sreg_n[DATA_W-1];
            end
            ACK: scl_low = (ph_n == 2'd0) || (ph_n == 2'd3);
            STO: begin
                scl_low = (ph_n == 2'd0);
                sda_low = (ph_n == 2'd0) || (ph_n == 2'd1);
            end
            default: ;
        endcase

        // BUSY rises one edge after acceptance and falls with DONE
        busy_n = (state != IDLE) && (state_n != IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            ph        <= 2'd0;
            bitc      <= 3'd0;
            bytec     <= '0;
            sreg      <= '0;
            lines     <= '0;
            scl_oe    <= '0;
            sda_oe    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
            nack_byte <= '0;
        end else begin
            state     <= state_n;
            div       <= (accept || tick) ? '0 : div + DIV_W'(1);
            ph        <= ph_n;
            bitc      <= bitc_n;
            bytec     <= bytec_n;
            sreg      <= sreg_n;
            lines     <= lines_n;
            scl_oe    <= scl_low ? lines_n : '0;
            sda_oe    <= sda_low ? lines_n : '0;
            busy      <= busy_n;
            done      <= done_n;
            nack      <= nack_n;
            nack_byte <= nack_byte_n;
        end
    end

    assign bus.scl_oe    = scl_oe;
    assign bus.sda_oe    = sda_oe;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.nack      = nack;
    assign bus.nack_byte = nack_byte;
endmodule
